oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequences the object-attribute-memory DMA copy: a write to the DMA page register copies LENGTH bytes from {page, 8'h00} to OAM offsets 8'h00 upward, one byte per M-cycle.
- Sits between the CPU register bus, the external/VRAM source bus and the OAM write port.
- While a copy is in progress it owns the source bus and blocks the CPU from it.
- All state advances only on the tick enable, one M-cycle per tick.

Parameters:
- LENGTH, 160, bytes per transfer; legal range 1..256.
- ARM_TICKS, 1, idle ticks between the register write and the first source read; legal range 1..4.
- PAGE_RESET, 8'hFF, reset value of the page register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- tick  in  1  M-cycle enable; state changes only on clk edges where tick=1.
- reg_wr  in  1  write strobe for the DMA page register; sampled only when tick=1.
- reg_wdata  in  8  page value that accompanies reg_wr.
- reg_rdata  out  8  last written page value, after remapping.
- dma_active  out  1  high from the tick that accepts reg_wr until the final OAM write has retired.
- cpu_bus_block  out  1  high while the controller owns the source bus (states ARM and XFER).
- src_rd  out  1  source read strobe.
- src_addr  out  16  source read address, {page, idx}.
- src_rdata  in  8  source data; valid in the same cycle as src_rd.
- oam_wr  out  1  OAM write strobe.
- oam_addr  out  8  OAM write offset.
- oam_wdata  out  8  OAM write data.

Behaviour:
- Reset values: state=IDLE, idx=0, arm_cnt=0, page=PAGE_RESET. All strobes are 0 and dma_active=0. reg_rdata=PAGE_RESET. src_addr=0, oam_addr=0, oam_wdata=0.
- State IDLE: a tick with reg_wr=1 latches the page, clears idx, sets arm_cnt=ARM_TICKS and moves to ARM.
- State ARM: each tick decrements arm_cnt. When arm_cnt reaches 0 the state moves to XFER, so the first src_rd occurs on the ARM_TICKS+1-th tick after the write.
- State XFER:
  - src_rd=1 and src_addr={page, idx[7:0]}.
  - On the tick, src_rdata is captured into a write stage with offset idx, and idx increments.
  - After the read at idx=LENGTH-1 the state moves to DRAIN.
- Write stage (one cycle behind the read):
  - On the tick after a captured read, oam_wr=1, oam_addr=captured idx and oam_wdata=captured byte.
  - The write stage operates independently of state changes.
- State DRAIN: issues the final OAM write, then returns to IDLE.
- Latency: the OAM write for offset n occurs ARM_TICKS+2+n ticks after the accepting tick. dma_active spans ARM_TICKS+LENGTH+1 ticks.
- Restart:
  - reg_wr in ARM, XFER or DRAIN latches the new page, clears idx, reloads arm_cnt and enters ARM.
  - dma_active stays high throughout; it is never deasserted between the two transfers.
  - A byte already captured in the write stage still retires on the following tick.
  - reg_wr on the same tick as the last XFER read: the restart wins, and the last byte still retires.
- Strobes are asserted only in cycles where tick=1; they are combinational from state qualified by tick.
- idx is 9 bits internally so that LENGTH=256 terminates correctly; src_addr and oam_addr use idx[7:0].
- Reset asserted mid-transfer: all outputs go to their reset values asynchronously, no further oam_wr occurs, and the page returns to PAGE_RESET.
- reg_rdata reflects the new page on the clk edge that accepts reg_wr.

Optional Feature:
- Macro: OAM_DMA_PAGE_REMAP_EN.
- Defined: written pages 8'hE0..8'hFF are stored as page-8'h20, i.e. C0..DF (echo-RAM mirror). reg_rdata returns the remapped value.
- Undefined: the page is stored and used verbatim.

Test Plan:
- Reset then idle: hold tick=1 for 10 cycles -> dma_active=0, src_rd=0, oam_wr=0, reg_rdata=8'hFF.
- Write 8'hC1 with a source model returning addr[7:0]^8'h5A:
  - first src_addr=16'hC100 on the 2nd tick after the write;
  - 160 OAM writes, oam_addr 0..159, data idx^8'h5A;
  - dma_active high for exactly 162 ticks.
- Tick gating: same as above with tick=1 every 4th clk -> identical sequence, with strobes only on tick cycles.
- Restart at idx=50 with page 8'h80:
  - OAM offset 49 is still written with the old data;
  - next src_addr=16'h8000 after 1 ARM tick;
  - dma_active never drops.
- Asynchronous reset pulse mid-XFER at idx=100 -> outputs clear immediately and no oam_wr follows.
- Write 8'hFE:
  - with OAM_DMA_PAGE_REMAP_EN: src_addr starts at 16'hDE00 and reg_rdata=8'hDE;
  - without it: src_addr starts at 16'hFE00.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: page write -> ARM_TICKS idle ticks -> LENGTH source reads, each retired to OAM one tick later.
// Optional macro OAM_DMA_PAGE_REMAP_EN folds written pages E0..FF onto C0..DF.
module oam_dma_ctrl #(
  parameter int         LENGTH     = 160,
  parameter int         ARM_TICKS  = 1,
  parameter logic [7:0] PAGE_RESET = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        dma_active,
  output logic        cpu_bus_block,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  typedef enum logic [1:0] {IDLE, ARM, XFER, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic [2:0] arm_q, arm_d;
  logic [7:0] page_q, page_in;
  logic       wr_pend_q;
  logic [7:0] wr_addr_q, wr_data_q;

`ifdef OAM_DMA_PAGE_REMAP_EN
  assign page_in = (reg_wdata >= 8'hE0) ? (reg_wdata - 8'h20) : reg_wdata;
`else
  assign page_in = reg_wdata;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    arm_d   = arm_q;
    case (state_q)
      IDLE: ;
      ARM: begin
        arm_d = arm_q - 3'd1;
        if (arm_q <= 3'd1) state_d = XFER;
      end
      XFER: begin
        idx_d = idx_q + 9'd1;
        if (idx_q == 9'(LENGTH - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A page write restarts from any state; the write stage is left alone.
    if (reg_wr) begin
      state_d = ARM;
      idx_d   = 9'd0;
      arm_d   = 3'(ARM_TICKS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 9'd0;
      arm_q   <= 3'd0;
      page_q  <= PAGE_RESET;
    end else if (tick) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      arm_q   <= arm_d;
      if (reg_wr) page_q <= page_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else if (tick) begin
      wr_pend_q <= (state_q == XFER);
      if (state_q == XFER) begin
        wr_addr_q <= idx_q[7:0];
        wr_data_q <= src_rdata;
      end
    end
  end

  assign reg_rdata     = page_q;
  assign dma_active    = (state_q != IDLE);
  assign cpu_bus_block = (state_q == ARM) || (state_q == XFER);
  assign src_rd        = tick && (state_q == XFER);
  assign src_addr      = (state_q == XFER) ? {page_q, idx_q[7:0]} : 16'h0000;
  assign oam_wr        = tick && wr_pend_q;
  assign oam_addr      = wr_addr_q;
  assign oam_wdata     = wr_data_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected reads/writes queued by stimulus, popped by a monitor.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset, tick, reg_wr;
  logic [7:0]  reg_wdata, reg_rdata, src_rdata, oam_addr, oam_wdata;
  logic        dma_active, cpu_bus_block, src_rd, oam_wr;
  logic [15:0] src_addr;

  int n_pass  = 0;
  int n_total = 0;
  int act_ticks = 0;

  logic [15:0] exp_src[$];
  logic [15:0] exp_oam[$];

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .dma_active(dma_active), .cpu_bus_block(cpu_bus_block),
    .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
    .oam_wr(oam_wr), .oam_addr(oam_addr), .oam_wdata(oam_wdata)
  );

  always #5 clk = ~clk;

  assign src_rdata = src_addr[7:0] ^ 8'h5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (tick) begin
        if (dma_active) act_ticks++;
        if (src_rd) begin
          check("src_rd expected", 32'(exp_src.size() != 0), 32'd1);
          check("bus block during read", 32'(cpu_bus_block), 32'd1);
          if (exp_src.size() != 0) check("src_addr", 32'(src_addr), 32'(exp_src.pop_front()));
        end
        if (oam_wr) begin
          check("oam_wr expected", 32'(exp_oam.size() != 0), 32'd1);
          if (exp_oam.size() != 0) check("oam addr/data", 32'({oam_addr, oam_wdata}), 32'(exp_oam.pop_front()));
        end
      end else begin
        check("strobes off-tick", 32'({src_rd, oam_wr}), 32'd0);
      end
    end
  end

  // One M-cycle: per-1 idle clocks, then one clock with tick=1.
  task automatic cyc(input logic w, input logic [7:0] d, input int per);
    for (int i = 0; i < per - 1; i++) begin
      tick = 1'b0; reg_wr = 1'b0;
      @(posedge clk); #1;
    end
    tick = 1'b1; reg_wr = w; reg_wdata = d;
    @(posedge clk); #1;
    tick = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic push_xfer(input logic [7:0] pg, input int last_rd, input int last_wr);
    for (int n = 0; n <= last_rd; n++) exp_src.push_back({pg, 8'(n)});
    for (int n = 0; n <= last_wr; n++) exp_oam.push_back({8'(n), 8'(n) ^ 8'h5A});
  endtask

  task automatic run_full(input string tag, input logic [7:0] wr_pg, input logic [7:0] exp_pg, input int per);
    act_ticks = 0;
    push_xfer(exp_pg, 159, 159);
    cyc(1'b1, wr_pg, per);
    check({tag, " reg_rdata"}, 32'(reg_rdata), 32'(exp_pg));
    cyc(1'b0, 8'h00, per);
    check({tag, " no read during arm"}, 32'(exp_src.size()), 32'd160);
    cyc(1'b0, 8'h00, per);
    check({tag, " first read on 2nd tick"}, 32'(exp_src.size()), 32'd159);
    repeat (163) cyc(1'b0, 8'h00, per);
    check({tag, " reads left"}, 32'(exp_src.size()), 32'd0);
    check({tag, " writes left"}, 32'(exp_oam.size()), 32'd0);
    check({tag, " active ticks"}, 32'(act_ticks), 32'd162);
    check({tag, " idle after"}, 32'(dma_active), 32'd0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; reg_wr = 1'b0; reg_wdata = 8'h00;
    #12 reset = 1'b0;
    @(posedge clk); #1;

    check("reset reg_rdata", 32'(reg_rdata), 32'hFF);
    check("reset dma_active", 32'(dma_active), 32'd0);
    check("reset bus block", 32'(cpu_bus_block), 32'd0);
    check("reset src_addr", 32'(src_addr), 32'd0);
    check("reset oam addr/data", 32'({oam_addr, oam_wdata}), 32'd0);
    act_ticks = 0;
    repeat (10) cyc(1'b0, 8'h00, 1);
    check("idle active ticks", 32'(act_ticks), 32'd0);
    check("idle reg_rdata", 32'(reg_rdata), 32'hFF);

    run_full("basic", 8'hC1, 8'hC1, 1);
    run_full("gated", 8'hC1, 8'hC1, 4);

    // Restart on the tick that reads idx 50.
    act_ticks = 0;
    push_xfer(8'hC1, 50, 50);
    push_xfer(8'h80, 159, 159);
    cyc(1'b1, 8'hC1, 1);
    repeat (51) cyc(1'b0, 8'h00, 1);
    cyc(1'b1, 8'h80, 1);
    check("restart reg_rdata", 32'(reg_rdata), 32'h80);
    check("restart old writes pending", 32'(exp_oam.size()), 32'd161);
    cyc(1'b0, 8'h00, 1);
    check("restart arm no read", 32'(exp_src.size()), 32'd160);
    check("restart old byte retired", 32'(exp_oam.size()), 32'd160);
    repeat (164) cyc(1'b0, 8'h00, 1);
    check("restart reads left", 32'(exp_src.size()), 32'd0);
    check("restart writes left", 32'(exp_oam.size()), 32'd0);
    check("restart active ticks", 32'(act_ticks), 32'd214);

    // Async reset with idx=100 and byte 99 waiting in the write stage.
    push_xfer(8'hC1, 99, 98);
    cyc(1'b1, 8'hC1, 1);
    repeat (101) cyc(1'b0, 8'h00, 1);
    check("pre-reset active", 32'(dma_active), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("areset dma_active", 32'(dma_active), 32'd0);
    check("areset src_addr", 32'(src_addr), 32'd0);
    check("areset oam addr/data", 32'({oam_addr, oam_wdata}), 32'd0);
    check("areset reg_rdata", 32'(reg_rdata), 32'hFF);
    tick = 1'b1;
    #1;
    check("areset strobes", 32'({src_rd, oam_wr, cpu_bus_block}), 32'd0);
    tick = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    check("areset reads done", 32'(exp_src.size()), 32'd0);
    check("areset writes done", 32'(exp_oam.size()), 32'd0);
    repeat (20) cyc(1'b0, 8'h00, 1);
    check("post-reset idle", 32'(dma_active), 32'd0);

`ifdef OAM_DMA_PAGE_REMAP_EN
    run_full("remap", 8'hFE, 8'hDE, 1);
`else
    run_full("verbatim", 8'hFE, 8'hFE, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
